// File: rtl/regbank_write_scheduler.sv
// Write-back scheduler: two per-requester FIFOs drained one entry per cycle
// by round-robin into the register bank, with per-register hazard tracking.
module regbank_wsched_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [4:0]  push_reg,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output logic [4:0]  head_reg,
  output logic [31:0] head_data
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    reg_q  [DEPTH];
  logic [4:0]    reg_d  [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign head_reg  = reg_q[rptr_q];
  assign head_data = data_q[rptr_q];

  always_comb begin
    reg_d  = reg_q;
    data_d = data_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      reg_d[wptr_q]  = push_reg;
      data_d[wptr_q] = push_data;
      wptr_d         = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
    reg_q  <= reg_d;
    data_q <= data_d;
  end
endmodule

module regbank_write_scheduler #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        AValid,
  input  logic [4:0]  ARegister,
  input  logic [31:0] AData,
  output logic        AReady,
  input  logic        BValid,
  input  logic [4:0]  BRegister,
  input  logic [31:0] BData,
  output logic        BReady,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        Hazard1,
  output logic        Hazard2,
  output logic        Idle
);
  logic        a_full, a_empty, b_full, b_empty;
  logic [4:0]  a_head_reg, b_head_reg;
  logic [31:0] a_head_data, b_head_data;
  logic        a_push, b_push;
  logic        pop_a, pop_b, pop_any;
  logic [4:0]  pop_reg;
  logic [31:0] pop_data;

  logic        last_b_q, last_b_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  write_register_q, write_register_d;
  logic [31:0] write_data_q, write_data_d;
  logic [2:0]  pend_q [32];
  logic [2:0]  pend_d [32];

  regbank_wsched_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk       (Clock),
    .rst       (Reset),
    .push      (a_push),
    .push_reg  (ARegister),
    .push_data (AData),
    .pop       (pop_a),
    .full      (a_full),
    .empty     (a_empty),
    .head_reg  (a_head_reg),
    .head_data (a_head_data)
  );

  regbank_wsched_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk       (Clock),
    .rst       (Reset),
    .push      (b_push),
    .push_reg  (BRegister),
    .push_data (BData),
    .pop       (pop_b),
    .full      (b_full),
    .empty     (b_empty),
    .head_reg  (b_head_reg),
    .head_data (b_head_data)
  );

  assign AReady = !a_full;
  assign BReady = !b_full;
  assign a_push = AValid && !a_full;
  assign b_push = BValid && !b_full;

  // last_b_q set means B was granted last, so A wins the next tie.
  assign pop_a    = !a_empty && (b_empty || last_b_q);
  assign pop_b    = !b_empty && !pop_a;
  assign pop_any  = pop_a || pop_b;
  assign pop_reg  = pop_a ? a_head_reg : b_head_reg;
  assign pop_data = pop_a ? a_head_data : b_head_data;

  always_comb begin
    last_b_d         = last_b_q;
    reg_write_d      = 1'b0;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    pend_d           = pend_q;
    if (pop_any) begin
      last_b_d         = pop_b;
      reg_write_d      = (pop_reg != 5'd0);
      write_register_d = pop_reg;
      write_data_d     = pop_data;
    end
    for (int i = 1; i < 32; i++) begin
      if (a_push && ARegister == 5'(i)) pend_d[i] = pend_d[i] + 3'd1;
      if (b_push && BRegister == 5'(i)) pend_d[i] = pend_d[i] + 3'd1;
      if (pop_any && pop_reg == 5'(i))  pend_d[i] = pend_d[i] - 3'd1;
    end
    pend_d[0] = 3'd0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      last_b_q         <= 1'b1;
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
      pend_q           <= '{default: '0};
    end else begin
      last_b_q         <= last_b_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
      pend_q           <= pend_d;
    end
  end

  assign RegWrite      = reg_write_q;
  assign WriteRegister = write_register_q;
  assign WriteData     = write_data_q;

  assign Hazard1 = (ReadRegister1 != 5'd0) &&
                   ((pend_q[ReadRegister1] != 3'd0) ||
                    (reg_write_q && write_register_q == ReadRegister1));
  assign Hazard2 = (ReadRegister2 != 5'd0) &&
                   ((pend_q[ReadRegister2] != 3'd0) ||
                    (reg_write_q && write_register_q == ReadRegister2));

  assign Idle = a_empty && b_empty && !reg_write_q;
endmodule

// File: tb/tb_regbank_write_scheduler.sv
// Directed bench for regbank_write_scheduler with DEPTH = 2.
// Inputs change 1ns after the rising edge; outputs sampled there too.
module tb_regbank_write_scheduler;
  logic        Clock = 1'b0;
  logic        Reset;
  logic        AValid, BValid;
  logic [4:0]  ARegister, BRegister;
  logic [31:0] AData, BData;
  logic        AReady, BReady;
  logic [4:0]  ReadRegister1, ReadRegister2;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        Hazard1, Hazard2, Idle;

  int total = 0;
  int fails = 0;

  logic [4:0]  a_regs [8];
  logic [4:0]  b_regs [8];
  logic [4:0]  log_reg [$];
  logic [31:0] log_data [$];
  int          log_edge [$];
  logic        bready_e2;
  int          wr_cnt;

  regbank_write_scheduler #(.DEPTH(2)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .AValid        (AValid),
    .ARegister     (ARegister),
    .AData         (AData),
    .AReady        (AReady),
    .BValid        (BValid),
    .BRegister     (BRegister),
    .BData         (BData),
    .BReady        (BReady),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .Hazard1       (Hazard1),
    .Hazard2       (Hazard2),
    .Idle          (Idle)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  // Both requesters offer their lists continuously, advancing on accept.
  // Data is 0xD000_0000 + register so it can be checked from the log.
  task automatic run_traffic(input int na, input int nb, input int edges);
    int  ai = 0;
    int  bi = 0;
    logic af, bf;
    log_reg.delete();
    log_data.delete();
    log_edge.delete();
    for (int n = 1; n <= edges; n++) begin
      AValid    = (ai < na);
      ARegister = AValid ? a_regs[ai] : 5'd0;
      AData     = 32'hD000_0000 + {27'd0, ARegister};
      BValid    = (bi < nb);
      BRegister = BValid ? b_regs[bi] : 5'd0;
      BData     = 32'hD000_0000 + {27'd0, BRegister};
      af = AValid && AReady;
      bf = BValid && BReady;
      tick();
      if (af) ai++;
      if (bf) bi++;
      if (n == 2) bready_e2 = BReady;
      if (RegWrite) begin
        log_reg.push_back(WriteRegister);
        log_data.push_back(WriteData);
        log_edge.push_back(n);
      end
    end
    AValid = 1'b0;
    BValid = 1'b0;
  endtask

  initial begin
    logic [4:0] exp38 [6];
    logic [4:0] exp39 [8];
    exp38 = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
    exp39 = '{5'd1, 5'd17, 5'd2, 5'd18, 5'd3, 5'd19, 5'd4, 5'd20};
    Reset = 1'b0;
    AValid = 1'b0; ARegister = '0; AData = '0;
    BValid = 1'b0; BRegister = '0; BData = '0;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
    bready_e2 = 1'b1;

    // Reset state
    do_reset();
    chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("rst_wreg", {27'd0, WriteRegister}, 32'd0);
    chk("rst_wdata", WriteData, 32'd0);
    chk("rst_aready", {31'd0, AReady}, 32'd1);
    chk("rst_bready", {31'd0, BReady}, 32'd1);
    chk("rst_idle", {31'd0, Idle}, 32'd1);
    chk("rst_haz1", {31'd0, Hazard1}, 32'd0);
    chk("rst_haz2", {31'd0, Hazard2}, 32'd0);

    // Single write of reg 5
    ReadRegister1 = 5'd5;
    AValid = 1'b1; ARegister = 5'd5; AData = 32'h0000_00AA;
    tick();
    AValid = 1'b0;
    chk("sw_e1_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("sw_e1_haz1", {31'd0, Hazard1}, 32'd1);
    chk("sw_e1_idle", {31'd0, Idle}, 32'd0);
    tick();
    chk("sw_e2_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("sw_e2_wreg", {27'd0, WriteRegister}, 32'd5);
    chk("sw_e2_wdata", WriteData, 32'h0000_00AA);
    chk("sw_e2_haz1", {31'd0, Hazard1}, 32'd1);
    tick();
    chk("sw_e3_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("sw_e3_haz1", {31'd0, Hazard1}, 32'd0);
    chk("sw_e3_wreg_hold", {27'd0, WriteRegister}, 32'd5);
    chk("sw_e3_wdata_hold", WriteData, 32'h0000_00AA);
    chk("sw_e3_idle", {31'd0, Idle}, 32'd1);

    // Register 0 write is consumed silently
    ReadRegister1 = 5'd0;
    AValid = 1'b1; ARegister = 5'd0; AData = 32'hFFFF_FFFF;
    tick();
    AValid = 1'b0;
    chk("r0_e1_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("r0_e1_haz1", {31'd0, Hazard1}, 32'd0);
    chk("r0_e1_idle", {31'd0, Idle}, 32'd0);
    tick();
    chk("r0_e2_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("r0_e2_haz1", {31'd0, Hazard1}, 32'd0);
    chk("r0_e2_idle", {31'd0, Idle}, 32'd1);

    // Contention: round-robin interleave, A first after reset
    do_reset();
    a_regs[0:2] = '{5'd1, 5'd2, 5'd3};
    b_regs[0:2] = '{5'd9, 5'd10, 5'd11};
    run_traffic(3, 3, 9);
    chk("cont_count", log_reg.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("cont_reg%0d", i), {27'd0, log_reg[i]}, {27'd0, exp38[i]});
    end
    chk("cont_first_edge", log_edge[0], 32'd2);
    chk("cont_span", log_edge[5] - log_edge[0], 32'd5);
    chk("cont_idle", {31'd0, Idle}, 32'd1);

    // Backpressure on B while A keeps the scheduler busy
    do_reset();
    a_regs[0:3] = '{5'd1, 5'd2, 5'd3, 5'd4};
    b_regs[0:3] = '{5'd17, 5'd18, 5'd19, 5'd20};
    run_traffic(4, 4, 12);
    chk("bp_bready_e2", {31'd0, bready_e2}, 32'd0);
    chk("bp_count", log_reg.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp_reg%0d", i), {27'd0, log_reg[i]}, {27'd0, exp39[i]});
      chk($sformatf("bp_data%0d", i), log_data[i],
          32'hD000_0000 + {27'd0, exp39[i]});
    end
    chk("bp_idle", {31'd0, Idle}, 32'd1);

    // Same register from both requesters on one edge
    do_reset();
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd7;
    AValid = 1'b1; ARegister = 5'd7; AData = 32'h0000_007A;
    BValid = 1'b1; BRegister = 5'd7; BData = 32'h0000_007B;
    tick();
    AValid = 1'b0; BValid = 1'b0;
    chk("pair_e1_haz2", {31'd0, Hazard2}, 32'd1);
    chk("pair_e1_haz1_r0", {31'd0, Hazard1}, 32'd0);
    tick();
    chk("pair_e2_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("pair_e2_wdata", WriteData, 32'h0000_007A);
    chk("pair_e2_haz2", {31'd0, Hazard2}, 32'd1);
    tick();
    chk("pair_e3_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("pair_e3_wdata", WriteData, 32'h0000_007B);
    chk("pair_e3_haz2", {31'd0, Hazard2}, 32'd1);
    tick();
    chk("pair_e4_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("pair_e4_haz2", {31'd0, Hazard2}, 32'd0);

    // Reset mid-operation discards queued writes
    do_reset();
    a_regs[0:2] = '{5'd12, 5'd13, 5'd14};
    b_regs[0:2] = '{5'd24, 5'd25, 5'd26};
    run_traffic(3, 3, 3);
    chk("mid_pre_aready", {31'd0, AReady}, 32'd0);
    chk("mid_pre_idle", {31'd0, Idle}, 32'd0);
    ReadRegister1 = 5'd13; ReadRegister2 = 5'd25;
    AValid = 1'b1; ARegister = 5'd14; AData = 32'h1;
    BValid = 1'b1; BRegister = 5'd26; BData = 32'h2;
    Reset = 1'b1;
    #1;
    chk("mid_rst_cycle_aready", {31'd0, AReady}, 32'd0);
    tick();
    Reset = 1'b0;
    AValid = 1'b0; BValid = 1'b0;
    chk("mid_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("mid_aready", {31'd0, AReady}, 32'd1);
    chk("mid_bready", {31'd0, BReady}, 32'd1);
    chk("mid_idle", {31'd0, Idle}, 32'd1);
    chk("mid_haz1", {31'd0, Hazard1}, 32'd0);
    chk("mid_haz2", {31'd0, Hazard2}, 32'd0);
    wr_cnt = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (RegWrite) wr_cnt++;
    end
    chk("mid_no_issue", wr_cnt, 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
